// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline issue arbiter and its tag delay line.
package pipe_ctrl_pkg;

  localparam int unsigned LATENCY_DEFAULT = 4;
  localparam int unsigned INSTR_W         = 8;
  localparam int unsigned OPC_W           = 4;
  localparam int unsigned NUM_REQ         = 2;
  localparam int unsigned ID_W            = 1;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_INC = 4'h1;
  localparam logic [OPC_W-1:0] OP_DEC = 4'h2;
  localparam logic [OPC_W-1:0] OP_SHL = 4'h3;
  localparam logic [OPC_W-1:0] OP_SHR = 4'h4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 4'h0};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // One-hot response strobe for a tag; empty (NOP) slots give all zeros.
  function automatic logic [NUM_REQ-1:0] tag_onehot(input tag_t t);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    if (t.valid) oh[t.id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pipe_issue_arbiter_if.sv
// Requester, pipeline and drain-control signals of the issue arbiter.
interface pipe_issue_arbiter_if;
  import pipe_ctrl_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  logic [INSTR_W-1:0] req_instr0;
  logic [INSTR_W-1:0] req_instr1;
  logic [NUM_REQ-1:0] req_ready;
  logic [INSTR_W-1:0] pipe_instr;
  logic [INSTR_W-1:0] pipe_result;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [INSTR_W-1:0] rsp_data;
  logic               drain;
  logic               drained;
  logic               busy;

  // Environment side: requesters, the execution pipeline and the drain controller.
  modport master (
    output req_valid, req_instr0, req_instr1, pipe_result, drain,
    input  req_ready, pipe_instr, rsp_valid, rsp_data, drained, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_instr0, req_instr1, pipe_result, drain,
    output req_ready, pipe_instr, rsp_valid, rsp_data, drained, busy
  );

endinterface

// File: rtl/pipe_tag_shifter.sv
// Delay line carrying {valid, id} alongside the instruction through the pipeline.
module pipe_tag_shifter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = LATENCY_DEFAULT + 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t head,
  output logic any_valid
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stages[i] <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) stages[i] <= stages[i-1];
    end
  end

  assign head = stages[DEPTH-1];

  // Any occupied slot means an issued instruction still awaits its response.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) any_valid = any_valid | stages[i].valid;
  end

endmodule

// File: rtl/pipe_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a fixed-latency pipeline, with
// response routing by tag and a drain/quiesce state machine.
module pipe_issue_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  pipe_issue_arbiter_if.slave bus
);

  state_t             state;
  logic               ptr;
  logic               drained_q;
  logic [INSTR_W-1:0] pipe_instr_q;

  logic [NUM_REQ-1:0] ready;
  logic [ID_W-1:0]    grant_id;
  logic               hs;
  logic [INSTR_W-1:0] grant_instr;
  tag_t               tag_in;
  tag_t               head;
  logic               busy;

  // Grant selection; drain in the same cycle blocks the grant.
  always_comb begin
    ready    = '0;
    grant_id = '0;
    if (state == ST_RUN && !bus.drain) begin
      if (bus.req_valid == 2'b11) begin
        grant_id = ptr;
        ready    = ptr ? 2'b10 : 2'b01;
      end else if (bus.req_valid[0]) begin
        ready = 2'b01;
      end else if (bus.req_valid[1]) begin
        grant_id = 1'b1;
        ready    = 2'b10;
      end
    end
  end

  assign hs          = |ready;
  assign grant_instr = grant_id[0] ? bus.req_instr1 : bus.req_instr0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = hs;
    tag_in.id    = grant_id;
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_instr_q <= NOP_INSTR;
      ptr          <= 1'b0;
    end else begin
      pipe_instr_q <= hs ? grant_instr : NOP_INSTR;
      if (hs) ptr <= ~grant_id[0];
    end
  end

  // Drain state machine; drained is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      drained_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.drain) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!busy) begin
            if (bus.drain) begin
              state     <= ST_DONE;
              drained_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          if (!bus.drain) begin
            state     <= ST_RUN;
            drained_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  pipe_tag_shifter #(
    .DEPTH(LATENCY + 1)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (tag_in),
    .head     (head),
    .any_valid(busy)
  );

  assign bus.req_ready  = ready;
  assign bus.pipe_instr = pipe_instr_q;
  assign bus.rsp_valid  = tag_onehot(head);
  assign bus.rsp_data   = bus.pipe_result;
  assign bus.drained    = drained_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Bench for pipe_issue_arbiter attached to a 4-stage execution pipeline model.
module tb_pipe_issue_arbiter;
  import pipe_ctrl_pkg::*;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_issue_arbiter_if bus ();

  pipe_issue_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] alu(input logic [7:0] ins);
    logic [7:0] opd;
    opd = {4'h0, ins[3:0]};
    case (ins[7:4])
      OP_INC:  return 8'(opd + 8'd1);
      OP_DEC:  return 8'(opd - 8'd1);
      OP_SHL:  return 8'(opd << 1);
      OP_SHR:  return 8'(opd >> 1);
      default: return 8'h00;
    endcase
  endfunction

  // Execution pipeline: result appears LAT edges after pipe_instr is presented.
  logic [7:0] stg [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) stg[i] <= 8'h00;
    end else begin
      stg[0] <= alu(bus.pipe_instr);
      for (int i = 1; i < int'(LAT); i++) stg[i] <= stg[i-1];
    end
  end
  assign bus.pipe_result = stg[LAT-1];

  typedef struct {
    logic [1:0] vld;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       mptr;
  state_t     mstate;
  logic [7:0] mpi;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mptr   = 1'b0;
    mstate = ST_RUN;
    mpi    = 8'h00;
  endtask

  // One clock cycle: check all outputs at negedge, advance the reference model.
  task automatic cycle();
    logic [1:0] er;
    logic       busy_e;
    exp_t       e;
    @(negedge clk);
    busy_e = (sb.size() != 0);
    er = 2'b00;
    if (mstate == ST_RUN && !bus.drain) begin
      if (bus.req_valid == 2'b11) er = mptr ? 2'b10 : 2'b01;
      else if (bus.req_valid[0])  er = 2'b01;
      else if (bus.req_valid[1])  er = 2'b10;
    end
    chk("req_ready", 8'(bus.req_ready), 8'(er));
    chk("busy", 8'(bus.busy), 8'(busy_e));
    chk("drained", 8'(bus.drained), 8'(mstate == ST_DONE));
    chk("pipe_instr", bus.pipe_instr, mpi);
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", 8'(bus.rsp_valid), 8'(e.vld));
      chk("rsp_data", bus.rsp_data, e.data);
    end else begin
      chk("rsp_idle", 8'(bus.rsp_valid), 8'h00);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (er != 2'b00) begin
        mpi = er[1] ? bus.req_instr1 : bus.req_instr0;
        sb.push_back('{vld: er, data: alu(mpi), due: cyc + int'(LAT) + 1});
        mptr = ~er[1];
      end else begin
        mpi = 8'h00;
      end
      case (mstate)
        ST_RUN:   if (bus.drain) mstate = ST_DRAIN;
        ST_DRAIN: if (!busy_e) mstate = bus.drain ? ST_DONE : ST_RUN;
        ST_DONE:  if (!bus.drain) mstate = ST_RUN;
        default:  mstate = ST_RUN;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 2'b00;
    repeat (n) cycle();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_instr0 = 8'h00;
    bus.req_instr1 = 8'h00;
    bus.drain      = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    idle(2);

    // Single requester 0: INC 5 -> 6
    bus.req_instr0 = 8'h15;
    bus.req_valid  = 2'b01;
    cycle();
    idle(7);

    // Both valid right after reset: req0 first, then req1
    pulse_reset();
    bus.req_instr0 = 8'h11;
    bus.req_instr1 = 8'h34;
    bus.req_valid  = 2'b11;
    cycle();
    cycle();
    idle(7);

    // Continuous contention for 8 cycles: alternating grants, no bubbles
    for (int i = 0; i < 8; i++) begin
      bus.req_instr0 = {OP_INC, 4'(i)};
      bus.req_instr1 = {OP_SHL, 4'(i + 3)};
      bus.req_valid  = 2'b11;
      cycle();
    end
    idle(7);

    // Three issued then drain, with req0 still requesting
    bus.req_valid  = 2'b01;
    bus.req_instr0 = 8'h2A;
    cycle();
    bus.req_instr0 = 8'h43;
    cycle();
    bus.req_instr0 = 8'h1F;
    cycle();
    bus.drain = 1'b1;
    repeat (12) cycle();
    bus.drain = 1'b0;
    repeat (3) cycle();
    idle(7);

    // Drain withdrawn while responses are still in flight
    bus.req_valid  = 2'b10;
    bus.req_instr1 = 8'h2C;
    cycle();
    bus.req_valid = 2'b00;
    bus.drain     = 1'b1;
    cycle();
    bus.drain = 1'b0;
    idle(8);

    // Reset two cycles after issuing: in-flight response is discarded
    bus.req_valid  = 2'b01;
    bus.req_instr0 = 8'h23;
    cycle();
    idle(1);
    pulse_reset();
    idle(8);

    // Invalid opcode from requester 1 yields zero data
    bus.req_valid  = 2'b10;
    bus.req_instr1 = 8'hF7;
    cycle();
    idle(7);

    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
